// File: rtl/bin_to_hex_ascii_tx.sv
// bin_to_hex_ascii_tx: serialises a captured binary word as ASCII hex characters, most-significant nibble first
module bin_to_hex_ascii_tx #(
    parameter int NIBBLES     = 8,
    parameter int UPPERCASE   = 0,
    parameter int SUPPRESS_LZ = 0,
    parameter int APPEND_NL   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [4*NIBBLES-1:0]   in_data,
    output logic                   in_ready,
    output logic                   char_valid,
    output logic [7:0]             char_data,
    output logic                   char_last,
    input  logic                   char_ready,
    output logic                   busy
);
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;
    state_t                 state_q;
    logic [4*NIBBLES-1:0]   word_q;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          start_d;
    logic [IW-1:0]          idx_m1;
    logic                   valid_q;
    logic                   last_q;
    logic                   ready_q;
    logic                   busy_q;
    logic [7:0]             data_q;
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'd0, n} : ((UPPERCASE != 0) ? 8'h37 : 8'h57) + {4'd0, n};
    endfunction
    function automatic logic [3:0] nib_at(input logic [4*NIBBLES-1:0] w, input int i);
        return w[4*i +: 4];
    endfunction
    // first digit to print: the top nibble, or the highest nonzero one when leading zeros are dropped
    always_comb begin
        start_d = IW'(NIBBLES - 1);
        idx_m1  = idx_q - IW'(1);
        if (SUPPRESS_LZ != 0) begin
            start_d = '0;
            for (int i = 0; i < NIBBLES; i++)
                if (nib_at(in_data, i) != 4'd0) start_d = IW'(i);
        end
    end
    // control FSM; character outputs are registered so they hold steady under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_q <= SEND;
                    word_q  <= in_data;
                    idx_q   <= start_d;
                    valid_q <= 1'b1;
                    data_q  <= hex_char(nib_at(in_data, int'(start_d)));
                    last_q  <= (start_d == '0) && (APPEND_NL == 0);
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                SEND: if (char_ready) begin
                    if (idx_q != '0) begin
                        idx_q  <= idx_m1;
                        data_q <= hex_char(nib_at(word_q, int'(idx_m1)));
                        last_q <= (idx_m1 == '0) && (APPEND_NL == 0);
                    end else if (APPEND_NL != 0) begin
                        state_q <= TERM;
                        data_q  <= 8'h0A;
                        last_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        data_q  <= 8'h00;
                        last_q  <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                TERM: if (char_ready) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    data_q  <= 8'h00;
                    last_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready   = ready_q;
    assign char_valid = valid_q;
    assign char_data  = data_q;
    assign char_last  = last_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_bin_to_hex_ascii_tx.sv
// tb_bin_to_hex_ascii_tx: random and directed checks of three configurations against a string-formatting model
module tb_bin_to_hex_ascii_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        char_ready = 1'b1;
    logic        cv [3];
    logic [7:0]  cd [3];
    logic        cl [3];
    logic        ir [3];
    logic        bz [3];
    logic [8:0]  expq [3][$];
    logic        stall [3];
    logic [8:0]  held [3];
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    bit          noise = 0;
    always #5 clk = ~clk;
    bin_to_hex_ascii_tx #(.NIBBLES(8), .UPPERCASE(0), .SUPPRESS_LZ(0), .APPEND_NL(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .char_valid(cv[0]), .char_data(cd[0]), .char_last(cl[0]), .char_ready(char_ready), .busy(bz[0]));
    bin_to_hex_ascii_tx #(.NIBBLES(8), .UPPERCASE(1), .SUPPRESS_LZ(1), .APPEND_NL(0)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .char_valid(cv[1]), .char_data(cd[1]), .char_last(cl[1]), .char_ready(char_ready), .busy(bz[1]));
    bin_to_hex_ascii_tx #(.NIBBLES(8), .UPPERCASE(0), .SUPPRESS_LZ(0), .APPEND_NL(1)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
        .char_valid(cv[2]), .char_data(cd[2]), .char_last(cl[2]), .char_ready(char_ready), .busy(bz[2]));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic void model(input int k, input logic [31:0] w, input bit up, input bit slz, input bit nl);
        string s;
        s = slz ? $sformatf("%0h", w) : $sformatf("%08h", w);
        if (up) s = s.toupper();
        for (int i = 0; i < s.len(); i++) expq[k].push_back({(i == s.len() - 1) && !nl, s[i]});
        if (nl) expq[k].push_back({1'b1, 8'h0A});
    endfunction
    // downstream readiness: tied high, a fixed 1,0,0,1 pattern, or random
    initial begin
        int p = 0;
        forever begin
            @(posedge clk); #1;
            char_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (p % 4 == 0 || p % 4 == 3) : 1'($urandom_range(0, 1));
            p++;
        end
    end
    // per-instance monitor: status vs. pending characters, hold under stall, character order and last flag
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) stall[k] = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [8:0] e;
                chk($sformatf("busy%0d", k), bz[k], expq[k].size() != 0);
                chk($sformatf("valid%0d", k), cv[k], expq[k].size() != 0);
                chk($sformatf("in_ready%0d", k), ir[k], expq[k].size() == 0);
                if (stall[k]) chk($sformatf("hold%0d", k), {cl[k], cd[k]}, held[k]);
                if (cv[k] && char_ready) begin
                    e = (expq[k].size() != 0) ? expq[k].pop_front() : 9'h1FF;
                    chk($sformatf("char%0d", k), cd[k], e[7:0]);
                    chk($sformatf("last%0d", k), cl[k], e[8]);
                end
                stall[k] = cv[k] && !char_ready;
                held[k]  = {cl[k], cd[k]};
            end
        end
    end
    task automatic send_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        model(0, w, 0, 0, 0);
        model(1, w, 1, 1, 0);
        model(2, w, 0, 0, 1);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (!(ir[0] && ir[1] && ir[2]) && n < 3000) begin
            @(posedge clk); #1;
            n++;
            in_data = $urandom;
            in_valid = noise && !ir[0] && !ir[1] && !ir[2] && ($urandom_range(0, 3) == 0);
        end
        in_valid = 1'b0;
        chk("idle_timeout", n < 3000, 1);
    endtask
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", cv[k], 0);
            chk("rst_data", cd[k], 0);
            chk("rst_last", cl[k], 0);
            chk("rst_busy", bz[k], 0);
            chk("rst_ready", ir[k], 1);
        end
        send_word(32'h1234ABCD);
        chk("latency", cv[0], 1);
        chk("first_char", cd[0], 8'h31);
        n = 0;
        while (!ir[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cycles_per_word", n + 1, 9);
        wait_idle();
        foreach (in_data[i]) ;
        send_word(32'hDEADBEEF); wait_idle();
        send_word(32'h000000F0); wait_idle();
        send_word(32'h00000000); wait_idle();
        send_word(32'h00000005); wait_idle();
        rdy_mode = 1;
        noise = 1;
        send_word(32'h89ABCDEF); wait_idle();
        noise = 0;
        rdy_mode = 0;
        @(posedge clk); #1;
        send_word(32'h0000ABCD);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) expq[k].delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_valid", cv[k], 0);
            chk("mid_rst_ready", ir[k], 1);
            chk("mid_rst_busy", bz[k], 0);
        end
        send_word(32'h00000001); wait_idle();
        rdy_mode = 2;
        noise = 1;
        for (int t = 0; t < 40; t++) begin
            logic [31:0] w;
            w = $urandom;
            w = w >> $urandom_range(0, 32);
            send_word(w);
            wait_idle();
        end
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) chk("drain", expq[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin_to_hex_ascii_tx.md
Name: bin_to_hex_ascii_tx

Overview:
- Converts a captured binary word into a serial stream of ASCII hexadecimal characters, most-significant nibble first.
- Provides the output path of the cache controller's trace and debug logging: binary addresses and data go out as printable hex text.
- This is the reverse of the trace-input hex path.
- Accepts one word at a time over a valid/ready handshake and emits one 8-bit character per accepted output handshake.

Parameters:
- NIBBLES, 8: number of hex digits per word; data width DATA_W = 4*NIBBLES.
- UPPERCASE, 0: 1 emits 'A'-'F' (0x41-0x46); 0 emits 'a'-'f' (0x61-0x66).
- SUPPRESS_LZ, 0: 1 drops leading zero nibbles; a word of 0 still emits a single '0'.
- APPEND_NL, 0: 1 appends a newline character (0x0A) after the last digit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_W  binary word to print.
- in_ready  output  1  block can accept a word.
- char_valid  output  1  char_data is valid.
- char_data  output  8  ASCII character.
- char_last  output  1  current character is the final one of the word.
- char_ready  input  1  downstream accepts char_data.
- busy  output  1  a word is being emitted (not IDLE).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- States: IDLE, SEND, TERM.
- Reset:
  - At the clk edge with rst=1, state returns to IDLE and the captured word and nibble index clear.
  - Outputs after reset: char_valid=0, char_data=0x00, char_last=0, busy=0, in_ready=1.
  - Reset mid-word discards the remaining characters. No partial char_last is emitted.
- IDLE:
  - in_ready=1, char_valid=0.
  - On in_valid&&in_ready, capture in_data into a holding register and go to SEND.
  - Start index: NIBBLES-1 when SUPPRESS_LZ=0; otherwise the index of the highest nonzero nibble (0 if the word is 0).
  - The first character is valid the cycle after capture (latency 1).
- SEND:
  - char_valid=1 and char_data = ASCII of the nibble at the current index.
  - Digit encoding: 0-9 map to 0x30-0x39; 10-15 map to letters per UPPERCASE.
  - On char_valid&&char_ready:
    - index>0: decrement the index.
    - index==0: go to TERM if APPEND_NL=1, otherwise to IDLE.
  - char_last=1 in SEND only when index==0 and APPEND_NL=0.
- TERM: char_valid=1, char_data=0x0A, char_last=1. On handshake, go to IDLE.
- Backpressure: while char_valid=1 and char_ready=0, char_data, char_last and the state hold stable.
- in_ready=0 in SEND and TERM; in_valid is ignored there. The upstream holds its word.
- Throughput with char_ready tied high: number of characters + 1 cycles per word. There is no IDLE bypass.
- busy=1 in SEND and TERM.
- in_data is sampled only in the capture cycle. Later changes to in_data must not affect the output.
- Characters emitted per word: 1 to NIBBLES digits, plus 1 if APPEND_NL=1.

Test Plan:
- Default params, in_data=0x1234ABCD, char_ready=1 -> chars 0x31,0x32,0x33,0x34,0x61,0x62,0x63,0x64 on consecutive cycles; char_last only on 0x64; in_ready back to 1 the next cycle.
- UPPERCASE=1, in_data=0xDEADBEEF -> "DEADBEEF" (0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46).
- SUPPRESS_LZ=1: in_data=0x000000F0 -> "f0" with char_last on '0'; in_data=0 -> single '0' (0x30) with char_last=1.
- APPEND_NL=1, in_data=0x00000005 -> "00000005" then 0x0A; char_last only on 0x0A.
- in_data=0x89ABCDEF with char_ready toggled 1,0,0,1,… -> char_data stable while stalled; sequence is exactly "89abcdef"; in_valid pulses during SEND are ignored (in_ready=0).
- rst asserted for one cycle after the third character -> next cycle char_valid=0, in_ready=1, busy=0; a new word 0x00000001 then emits a full fresh "00000001".
